// File: rtl/me_search_ctrl.sv
// Full-search motion-estimation sequencer: loads the current block, issues every
// candidate vector in raster order, tracks the minimum returned SAD. Optional: ME_EARLY_TERM_EN.
module me_search_ctrl #(
   parameter int SAD_W    = 14,
   parameter int MV_W     = 4,
   parameter int TERM_THR = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             crt_keep,
   output logic             cand_valid,
   input  logic             cand_ready,
   output logic [MV_W-1:0]  cand_x,
   output logic [MV_W-1:0]  cand_y,
   input  logic             sad_valid,
   input  logic [SAD_W-1:0] sad_total,
   output logic             busy,
   output logic             done,
   output logic [SAD_W-1:0] sad_min,
   output logic [MV_W-1:0]  motion_vec_x_min,
   output logic [MV_W-1:0]  motion_vec_y_min
);

   localparam int CNT_W = 2*MV_W + 1;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] outstanding;
   logic [MV_W-1:0]  ret_x, ret_y;
   logic [MV_W-1:0]  run_x, run_y;
   logic [SAD_W-1:0] run_min;

   logic             xfer, sad_acc, better, last_cand, drained, stop_early;
   logic [SAD_W-1:0] min_nxt;
   logic [MV_W-1:0]  x_nxt, y_nxt;

   assign xfer      = cand_valid && cand_ready;
   // A return with nothing outstanding is spurious and must not disturb tracking.
   assign sad_acc   = sad_valid && (outstanding != '0);
   assign better    = sad_acc && (sad_total < run_min);
   assign min_nxt   = better ? sad_total : run_min;
   assign x_nxt     = better ? ret_x : run_x;
   assign y_nxt     = better ? ret_y : run_y;
   assign last_cand = (&cand_x) && (&cand_y);
   assign drained   = (outstanding == '0) || ((outstanding == CNT_W'(1)) && sad_acc);

`ifdef ME_EARLY_TERM_EN
   assign stop_early = sad_acc && (sad_total <= SAD_W'(TERM_THR));
`else
   assign stop_early = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state            <= S_IDLE;
         crt_keep         <= 1'b1;
         cand_valid       <= 1'b0;
         cand_x           <= '0;
         cand_y           <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         sad_min          <= '1;
         motion_vec_x_min <= '0;
         motion_vec_y_min <= '0;
         outstanding      <= '0;
         ret_x            <= '0;
         ret_y            <= '0;
         run_x            <= '0;
         run_y            <= '0;
         run_min          <= '1;
      end else begin
         outstanding <= outstanding + CNT_W'(xfer) - CNT_W'(sad_acc);
         if (sad_acc) begin
            run_min        <= min_nxt;
            run_x          <= x_nxt;
            run_y          <= y_nxt;
            {ret_y, ret_x} <= {ret_y, ret_x} + (2*MV_W)'(1);
         end

         case (state)
            S_IDLE: begin
               if (start) begin
                  state          <= S_LOAD;
                  busy           <= 1'b1;
                  crt_keep       <= 1'b0;
                  run_min        <= '1;
                  run_x          <= '0;
                  run_y          <= '0;
                  {ret_y, ret_x} <= '0;
                  cand_x         <= '0;
                  cand_y         <= '0;
               end
            end
            S_LOAD: begin
               state      <= S_ISSUE;
               crt_keep   <= 1'b1;
               cand_valid <= 1'b1;
            end
            S_ISSUE: begin
               if ((xfer && last_cand) || stop_early) begin
                  state      <= S_DRAIN;
                  cand_valid <= 1'b0;
               end else if (xfer) begin
                  if (&cand_x) begin
                     cand_x <= '0;
                     cand_y <= cand_y + MV_W'(1);
                  end else begin
                     cand_x <= cand_x + MV_W'(1);
                  end
               end
            end
            S_DRAIN: begin
               // Capture the post-update running values so a final return in this cycle counts.
               if (drained) begin
                  state            <= S_DONE;
                  done             <= 1'b1;
                  sad_min          <= min_nxt;
                  motion_vec_x_min <= x_nxt;
                  motion_vec_y_min <= y_nxt;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_me_search_ctrl.sv
// Directed bench for me_search_ctrl: a fetch/SAD responder with fixed return latency,
// per-scenario tasks with inline expected-value checks.
module tb_me_search_ctrl;

   logic        clk = 1'b0;
   logic        rst, start, cand_ready, sad_valid;
   logic [13:0] sad_total;
   logic        crt_keep, cand_valid, busy, done;
   logic [3:0]  cand_x, cand_y, mvx, mvy;
   logic [13:0] sad_min;

   me_search_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .crt_keep(crt_keep),
      .cand_valid(cand_valid), .cand_ready(cand_ready), .cand_x(cand_x), .cand_y(cand_y),
      .sad_valid(sad_valid), .sad_total(sad_total), .busy(busy), .done(done),
      .sad_min(sad_min), .motion_vec_x_min(mvx), .motion_vec_y_min(mvy)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;
   int pat, abort_at;
   bit rnd_ready, hold_start;
   int xfer_cnt, order_err, stab_err, keep0_cnt, done_cnt, cyc_done;
   bit timeout, aborted;
   logic after_busy, after_done;

   function automatic logic [13:0] sad_of(int p, int x, int y);
      case (p)
         0: return (x == 5 && y == 9) ? 14'd37 : 14'd100;
         1: return ((x == 3 || x == 7) && y == 2) ? 14'd20 : 14'd50;
         2: return (x == 15 && y == 15) ? 14'd12 : 14'(300 + x);
         default: return (x == 8 && y == 2) ? 14'd0 : 14'd90;
      endcase
   endfunction

   // Drives one search: responder returns each SAD 3 cycles after its transfer.
   task automatic run_search();
      int q_idx[$];
      int q_due[$];
      int cyc;
      int idx;
      bit pstall;
      logic [3:0] px, py;
      xfer_cnt = 0; order_err = 0; stab_err = 0; keep0_cnt = 0; done_cnt = 0;
      cyc_done = 0; timeout = 0; aborted = 0; pstall = 0; px = 0; py = 0;
      @(negedge clk);
      start = 1'b1;
      cyc = 0;
      while (cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (!hold_start) start = 1'b0;
         if (crt_keep === 1'b0) keep0_cnt++;
         if (done === 1'b1) begin
            done_cnt++;
            cyc_done = cyc;
            break;
         end
         if (pstall && cand_valid === 1'b1 && (cand_x !== px || cand_y !== py)) stab_err++;
         sad_valid = 1'b0;
         if (q_idx.size() > 0 && q_due[0] <= cyc) begin
            sad_valid = 1'b1;
            sad_total = sad_of(pat, q_idx[0] % 16, q_idx[0] / 16);
            void'(q_idx.pop_front());
            void'(q_due.pop_front());
         end
         cand_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (cand_valid === 1'b1 && cand_ready) begin
            idx = int'(cand_y) * 16 + int'(cand_x);
            if (idx != xfer_cnt) order_err++;
            q_idx.push_back(idx);
            q_due.push_back(cyc + 3);
            xfer_cnt++;
         end
         pstall = (cand_valid === 1'b1) && !cand_ready;
         px = cand_x;
         py = cand_y;
         if (abort_at > 0 && xfer_cnt == abort_at) begin
            aborted = 1;
            break;
         end
      end
      if (done_cnt == 0 && !aborted) timeout = 1;
      start = 1'b0;
      sad_valid = 1'b0;
      cand_ready = 1'b0;
      if (!aborted && !timeout) begin
         @(negedge clk);
         after_busy = busy;
         after_done = done;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 0; cand_ready = 0; sad_valid = 0; sad_total = 0;
      #12;
      n_chk++; if (crt_keep !== 1'b1) begin n_fail++; $display("FAIL reset_crt_keep: got %b expected 1", crt_keep); end
      n_chk++; if (cand_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cand_valid: got %b expected 0", cand_valid); end
      n_chk++; if ({cand_x, cand_y} !== 8'h00) begin n_fail++; $display("FAIL reset_cand_xy: got %h expected 00", {cand_x, cand_y}); end
      n_chk++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_done: got %b expected 00", {busy, done}); end
      n_chk++; if (sad_min !== 14'h3FFF) begin n_fail++; $display("FAIL reset_sad_min: got %h expected 3fff", sad_min); end
      n_chk++; if ({mvx, mvy} !== 8'h00) begin n_fail++; $display("FAIL reset_mv: got %h expected 00", {mvx, mvy}); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_min_search();
      pat = 0; rnd_ready = 0; hold_start = 0; abort_at = 0;
      run_search();
      n_chk++; if (keep0_cnt != 1) begin n_fail++; $display("FAIL min_keep0: got %0d expected 1", keep0_cnt); end
      n_chk++; if (xfer_cnt != 256) begin n_fail++; $display("FAIL min_xfers: got %0d expected 256", xfer_cnt); end
      n_chk++; if (order_err != 0) begin n_fail++; $display("FAIL min_order: got %0d errors expected 0", order_err); end
      n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL min_done: got %0d expected 1", done_cnt); end
      n_chk++; if (cyc_done != 261) begin n_fail++; $display("FAIL min_latency: got %0d expected 261", cyc_done); end
      n_chk++; if (sad_min !== 14'd37) begin n_fail++; $display("FAIL min_sad: got %0d expected 37", sad_min); end
      n_chk++; if ({mvx, mvy} !== {4'd5, 4'd9}) begin n_fail++; $display("FAIL min_vec: got %0d,%0d expected 5,9", mvx, mvy); end
      n_chk++; if ({after_busy, after_done} !== 2'b00) begin n_fail++; $display("FAIL min_after: got %b expected 00", {after_busy, after_done}); end
   endtask

   task automatic test_tie_and_busy_start();
      pat = 1; rnd_ready = 0; hold_start = 1; abort_at = 0;
      run_search();
      n_chk++; if (keep0_cnt != 1) begin n_fail++; $display("FAIL tie_keep0: got %0d expected 1", keep0_cnt); end
      n_chk++; if (sad_min !== 14'd20) begin n_fail++; $display("FAIL tie_sad: got %0d expected 20", sad_min); end
      n_chk++; if ({mvx, mvy} !== {4'd3, 4'd2}) begin n_fail++; $display("FAIL tie_vec: got %0d,%0d expected 3,2", mvx, mvy); end
      n_chk++; if (after_busy !== 1'b0) begin n_fail++; $display("FAIL tie_start_in_done: got busy %b expected 0", after_busy); end
      hold_start = 0;
   endtask

   task automatic test_ready_stall();
      pat = 2; rnd_ready = 1; hold_start = 0; abort_at = 0;
      run_search();
      n_chk++; if (xfer_cnt != 256) begin n_fail++; $display("FAIL stall_xfers: got %0d expected 256", xfer_cnt); end
      n_chk++; if (order_err != 0) begin n_fail++; $display("FAIL stall_order: got %0d errors expected 0", order_err); end
      n_chk++; if (stab_err != 0) begin n_fail++; $display("FAIL stall_stable: got %0d errors expected 0", stab_err); end
      n_chk++; if (sad_min !== 14'd12) begin n_fail++; $display("FAIL stall_sad: got %0d expected 12", sad_min); end
      n_chk++; if ({mvx, mvy} !== {4'd15, 4'd15}) begin n_fail++; $display("FAIL stall_vec: got %0d,%0d expected 15,15", mvx, mvy); end
   endtask

   task automatic test_ignored();
      sad_total = 14'd0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         sad_valid = 1'b1;
      end
      @(negedge clk);
      sad_valid = 1'b0;
      @(negedge clk);
      n_chk++; if (sad_min !== 14'd12) begin n_fail++; $display("FAIL idle_sad: got %0d expected 12", sad_min); end
      n_chk++; if ({mvx, mvy} !== {4'd15, 4'd15}) begin n_fail++; $display("FAIL idle_vec: got %0d,%0d expected 15,15", mvx, mvy); end
      n_chk++; if ({busy, done, cand_valid} !== 3'b000) begin n_fail++; $display("FAIL idle_ctrl: got %b expected 000", {busy, done, cand_valid}); end
   endtask

   task automatic test_abort();
      pat = 0; rnd_ready = 0; hold_start = 0; abort_at = 100;
      run_search();
      rst = 1'b0;
      #1;
      n_chk++; if (done_cnt != 0) begin n_fail++; $display("FAIL abort_done: got %0d expected 0", done_cnt); end
      n_chk++; if ({busy, done, cand_valid, crt_keep} !== 4'b0001) begin n_fail++; $display("FAIL abort_ctrl: got %b expected 0001", {busy, done, cand_valid, crt_keep}); end
      n_chk++; if (sad_min !== 14'h3FFF) begin n_fail++; $display("FAIL abort_sad: got %h expected 3fff", sad_min); end
      n_chk++; if ({mvx, mvy, cand_x, cand_y} !== 16'h0000) begin n_fail++; $display("FAIL abort_vec: got %h expected 0000", {mvx, mvy, cand_x, cand_y}); end
      @(negedge clk);
      rst = 1'b1;
      pat = 1; abort_at = 0;
      run_search();
      n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL rerun_done: got %0d expected 1", done_cnt); end
      n_chk++; if (xfer_cnt != 256) begin n_fail++; $display("FAIL rerun_xfers: got %0d expected 256", xfer_cnt); end
      n_chk++; if ({sad_min, mvx, mvy} !== {14'd20, 4'd3, 4'd2}) begin n_fail++; $display("FAIL rerun_result: got %0d@%0d,%0d expected 20@3,2", sad_min, mvx, mvy); end
   endtask

`ifdef ME_EARLY_TERM_EN
   task automatic test_early_term();
      pat = 3; rnd_ready = 0; hold_start = 0; abort_at = 0;
      run_search();
      n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL et_done: got %0d expected 1", done_cnt); end
      n_chk++; if (xfer_cnt > 44 || xfer_cnt < 41) begin n_fail++; $display("FAIL et_xfers: got %0d expected 41..44", xfer_cnt); end
      n_chk++; if ({sad_min, mvx, mvy} !== {14'd0, 4'd8, 4'd2}) begin n_fail++; $display("FAIL et_result: got %0d@%0d,%0d expected 0@8,2", sad_min, mvx, mvy); end
   endtask
`endif

   initial begin
      test_reset();
      test_min_search();
      test_tie_and_busy_start();
      test_ready_stall();
      test_ignored();
      test_abort();
`ifdef ME_EARLY_TERM_EN
      test_early_term();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
